path_buffer_ctrl: RTL and testbench

- Controller plus storage for the move stack/queue shared by the maze-solver controller and the path-replay stage.
- Solve phase: LIFO of 2-bit moves, with push/pop and a combinational top value for backtracking.
- Replay phase: the same contents are read FIFO-style from the bottom entry, paced at one move per STEP_CYCLES cycles, ending with a done pulse.
- The block owns the stack pointer, the read pointer, the mode FSM and the full/empty flags.

---
 rtl/path_pkg.sv | 21 ++
 rtl/path_mem.sv | 30 +++
 rtl/path_buffer_ctrl.sv | 145 ++++++++++++++
 tb/tb_path_buffer_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/path_pkg.sv
// Shared types for the move stack: direction encoding, controller mode, reversal helper.
package path_pkg;

   typedef logic [1:0] dir_t;

   localparam dir_t DIR_UP    = 2'b00;
   localparam dir_t DIR_RIGHT = 2'b01;
   localparam dir_t DIR_LEFT  = 2'b10;
   localparam dir_t DIR_DOWN  = 2'b11;

   typedef enum logic {
      S_STACK  = 1'b0,
      S_REPLAY = 1'b1
   } state_t;

   // The encoding puts each direction's reverse at its bitwise complement.
   function automatic dir_t opposite(input dir_t d);
      return ~d;
   endfunction

endpackage

// File: rtl/path_mem.sv
// DEPTH x 2-bit move storage: one synchronous write port, two asynchronous read ports.
// Latency: writes visible the cycle after the edge; reads are combinational. No backpressure.
module path_mem
   import path_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          CLK,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  dir_t          i_wdat,
   input  logic [AW-1:0] i_top_addr,
   output dir_t          o_top_dat,
   input  logic [AW-1:0] i_rd_addr,
   output dir_t          o_rd_dat
);

   dir_t r_mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdat;
      end
   end

   assign o_top_dat = r_mem[i_top_addr];
   assign o_rd_dat  = r_mem[i_rd_addr];

endmodule

// File: rtl/path_buffer_ctrl.sv
// Move stack for the solver (LIFO push/pop/replace) with paced FIFO-order replay ending in a done pulse.
// Latency: replay emits its first move STEP_CYCLES edges after read is taken; optional macro CANCEL_PAIR_EN.
module path_buffer_ctrl
   import path_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int STEP_CYCLES = 4
) (
   input  logic       CLK,
   input  logic       Rst,
   input  logic       clr,
   input  logic       push,
   input  logic       pop,
   input  logic [1:0] data_in,
   output logic [1:0] top_value,
   output logic       empty,
   output logic       full,
   input  logic       read,
   output logic [1:0] move_out,
   output logic       move_valid,
   output logic       done
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(STEP_CYCLES - 1);
   localparam logic [AW:0]   SP_FULL  = (AW+1)'(DEPTH);
   localparam logic [AW:0]   SP_ONE   = (AW+1)'(1);

   state_t        r_state, w_state_nxt;
   logic [AW:0]   r_sp, w_sp_nxt;
   logic [AW:0]   r_rd_ptr, w_rd_ptr_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   dir_t          r_move_out, w_move_out_nxt;
   logic          r_move_valid, w_move_valid_nxt;
   logic          r_done, w_done_nxt;

   logic          w_we;
   logic [AW-1:0] w_waddr;
   logic [AW-1:0] w_top_addr;
   dir_t          w_top_dat;
   dir_t          w_rd_dat;
   logic          w_cancel;

   assign w_top_addr = r_sp[AW-1:0] - AW'(1);
   assign empty      = (r_sp == '0);
   assign full       = (r_sp == SP_FULL);
   assign top_value  = empty ? DIR_UP : w_top_dat;
   assign move_out   = r_move_out;
   assign move_valid = r_move_valid;
   assign done       = r_done;

`ifdef CANCEL_PAIR_EN
   // A push that reverses the last move undoes it instead of being stored.
   assign w_cancel = push && !pop && !empty && (data_in == opposite(top_value));
`else
   assign w_cancel = 1'b0;
`endif

   path_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .CLK        (CLK),
      .i_we       (w_we),
      .i_waddr    (w_waddr),
      .i_wdat     (data_in),
      .i_top_addr (w_top_addr),
      .o_top_dat  (w_top_dat),
      .i_rd_addr  (r_rd_ptr[AW-1:0]),
      .o_rd_dat   (w_rd_dat)
   );

   always_comb begin
      w_state_nxt      = r_state;
      w_sp_nxt         = r_sp;
      w_rd_ptr_nxt     = r_rd_ptr;
      w_cnt_nxt        = r_cnt;
      w_move_out_nxt   = r_move_out;
      w_move_valid_nxt = 1'b0;
      w_done_nxt       = 1'b0;
      w_we             = 1'b0;
      w_waddr          = r_sp[AW-1:0];

      unique case (r_state)
         S_STACK: begin
            if (w_cancel) begin
               w_sp_nxt = r_sp - SP_ONE;
            end else if (push && pop && !empty) begin
               w_we    = 1'b1;
               w_waddr = w_top_addr;
            end else if (push && !full) begin
               // Also covers push+pop on an empty stack.
               w_we     = 1'b1;
               w_sp_nxt = r_sp + SP_ONE;
            end else if (pop && !push && !empty) begin
               w_sp_nxt = r_sp - SP_ONE;
            end else if (read && !push && !pop) begin
               w_state_nxt  = S_REPLAY;
               w_rd_ptr_nxt = '0;
               w_cnt_nxt    = CNT_LOAD;
            end
         end
         S_REPLAY: begin
            if (!read) begin
               w_state_nxt  = S_STACK;
               w_rd_ptr_nxt = '0;
            end else if (r_rd_ptr == r_sp) begin
               w_done_nxt   = 1'b1;
               w_state_nxt  = S_STACK;
               w_rd_ptr_nxt = '0;
            end else if (r_cnt == '0) begin
               w_move_out_nxt   = w_rd_dat;
               w_move_valid_nxt = 1'b1;
               w_rd_ptr_nxt     = r_rd_ptr + SP_ONE;
               w_cnt_nxt        = CNT_LOAD;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         default: w_state_nxt = S_STACK;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Rst || clr) begin
         r_state      <= S_STACK;
         r_sp         <= '0;
         r_rd_ptr     <= '0;
         r_cnt        <= '0;
         r_move_out   <= DIR_UP;
         r_move_valid <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_sp         <= w_sp_nxt;
         r_rd_ptr     <= w_rd_ptr_nxt;
         r_cnt        <= w_cnt_nxt;
         r_move_out   <= w_move_out_nxt;
         r_move_valid <= w_move_valid_nxt;
         r_done       <= w_done_nxt;
      end
   end

endmodule

// File: tb/tb_path_buffer_ctrl.sv
// Scoreboard bench for path_buffer_ctrl (DEPTH=4, STEP_CYCLES=4); expectations follow CANCEL_PAIR_EN.
module tb_path_buffer_ctrl;
   import path_pkg::*;

   localparam int DEPTH = 4;
   localparam int STEP  = 4;

   logic       CLK = 1'b0;
   logic       Rst = 1'b1;
   logic       clr = 1'b0;
   logic       push = 1'b0;
   logic       pop = 1'b0;
   logic       read = 1'b0;
   logic [1:0] data_in = 2'b00;
   logic [1:0] top_value, move_out;
   logic       empty, full, move_valid, done;

   path_buffer_ctrl #(.DEPTH(DEPTH), .STEP_CYCLES(STEP)) dut (
      .CLK(CLK), .Rst(Rst), .clr(clr), .push(push), .pop(pop), .data_in(data_in),
      .top_value(top_value), .empty(empty), .full(full), .read(read),
      .move_out(move_out), .move_valid(move_valid), .done(done)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string      name;
      logic [1:0] top;
      logic       emp;
      logic       ful;
      int         sp;
      logic [1:0] mo;
   } stat_t;

   typedef struct {
      logic       is_done;
      logic [1:0] mv;
      int         at;
   } ev_t;

   stat_t sq[$];
   ev_t   eq[$];
   event  chk_ev;

   // Status monitor: compares queued snapshots of the stack-side outputs on request.
   always begin
      stat_t s;
      @(chk_ev);
      while (sq.size() > 0) begin
         s = sq.pop_front();
         total++;
         if (top_value !== s.top || empty !== s.emp || full !== s.ful ||
             int'(dut.r_sp) != s.sp || move_out !== s.mo) begin
            bad++;
            $display("FAIL %s: got top=%b empty=%b full=%b sp=%0d move_out=%b, want top=%b empty=%b full=%b sp=%0d move_out=%b",
                     s.name, top_value, empty, full, int'(dut.r_sp), move_out,
                     s.top, s.emp, s.ful, s.sp, s.mo);
         end
      end
   end

   // Replay monitor: every move_valid/done pulse must match the next queued event and its cycle.
   always @(negedge CLK) begin
      ev_t e;
      if (move_valid || done) begin
         total++;
         if (eq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse: got move_valid=%b done=%b move_out=%b at cycle %0d, want no pulse",
                     move_valid, done, move_out, cyc);
         end else begin
            e = eq.pop_front();
            if (done !== e.is_done || move_valid === e.is_done ||
                (!e.is_done && move_out !== e.mv) || cyc != e.at) begin
               bad++;
               $display("FAIL replay_event: got done=%b move_valid=%b move_out=%b cycle=%0d, want done=%b move_out=%b cycle=%0d",
                        done, move_valid, move_out, cyc, e.is_done, e.mv, e.at);
            end
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic op(input logic ps, input logic pp, input logic [1:0] d);
      push = ps; pop = pp; data_in = d;
      step();
      push = 1'b0; pop = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   task automatic expect_stat(input string n, input logic [1:0] t, input logic e,
                              input logic f, input int sp, input logic [1:0] mo);
      stat_t s;
      s.name = n; s.top = t; s.emp = e; s.ful = f; s.sp = sp; s.mo = mo;
      sq.push_back(s);
      -> chk_ev;
      #1;
   endtask

   task automatic expect_ev(input logic isd, input logic [1:0] mv, input int at);
      ev_t e;
      e.is_done = isd; e.mv = mv; e.at = at;
      eq.push_back(e);
   endtask

   task automatic run_to(input int target);
      int i = 0;
      while (cyc < target && i < 200) begin
         step();
         i++;
      end
   endtask

   task automatic drain(input string n, input int budget);
      int i = 0;
      while (eq.size() > 0 && i < budget) begin
         step();
         i++;
      end
      total++;
      if (eq.size() != 0) begin
         bad++;
         $display("FAIL %s: got %0d replay events still pending, want 0", n, eq.size());
         eq.delete();
      end
   endtask

   task automatic check_state(input string n, input state_t want);
      total++;
      if (dut.r_state !== want) begin
         bad++;
         $display("FAIL %s: got state=%0d, want %0d", n, dut.r_state, want);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by time limit, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      step();
      step();
      Rst = 1'b0;
      expect_stat("reset", 2'b00, 1'b1, 1'b0, 0, 2'b00);

      // Stack push/pop and underflow
      op(1, 0, 2'b00);
      op(1, 0, 2'b01);
      op(1, 0, 2'b11);
      expect_stat("t1_push3", 2'b11, 1'b0, 1'b0, 3, 2'b00);
      op(0, 1, 2'b00);
      expect_stat("t1_pop1", 2'b01, 1'b0, 1'b0, 2, 2'b00);
      op(0, 1, 2'b00);
      op(0, 1, 2'b00);
      expect_stat("t1_pop3", 2'b00, 1'b1, 1'b0, 0, 2'b00);
      op(0, 1, 2'b00);
      expect_stat("t1_pop_empty", 2'b00, 1'b1, 1'b0, 0, 2'b00);

      // Fill, overflow push, replace at full
      repeat (4) op(1, 0, 2'b01);
      expect_stat("t2_full", 2'b01, 1'b0, 1'b1, 4, 2'b00);
      op(1, 0, 2'b10);
`ifdef CANCEL_PAIR_EN
      expect_stat("t2_push_full", 2'b01, 1'b0, 1'b0, 3, 2'b00);
      op(1, 1, 2'b10);
      expect_stat("t2_replace", 2'b10, 1'b0, 1'b0, 3, 2'b00);
`else
      expect_stat("t2_push_full", 2'b01, 1'b0, 1'b1, 4, 2'b00);
      op(1, 1, 2'b10);
      expect_stat("t2_replace", 2'b10, 1'b0, 1'b1, 4, 2'b00);
`endif

      // Reversal pair
      do_clr();
      expect_stat("t6_clr", 2'b00, 1'b1, 1'b0, 0, 2'b00);
      op(1, 0, 2'b00);
      op(1, 0, 2'b11);
`ifdef CANCEL_PAIR_EN
      expect_stat("t6_cancel", 2'b00, 1'b1, 1'b0, 0, 2'b00);
`else
      expect_stat("t6_nocancel", 2'b11, 1'b0, 1'b0, 2, 2'b00);
`endif

      // Replay of {00,01,10}, restart after done, then abort
      do_clr();
      op(1, 0, 2'b00);
      op(1, 0, 2'b01);
      op(1, 0, 2'b01);
      op(1, 1, 2'b10);
      expect_stat("t3_stack", 2'b10, 1'b0, 1'b0, 3, 2'b00);
      k = cyc + 1;
      read = 1'b1;
      expect_ev(1'b0, 2'b00, k + 4);
      expect_ev(1'b0, 2'b01, k + 8);
      expect_ev(1'b0, 2'b10, k + 12);
      expect_ev(1'b1, 2'b00, k + 13);
      expect_ev(1'b0, 2'b00, k + 18);
      run_to(k + 18);
      read = 1'b0;
      drain("t3_replay", 40);
      repeat (12) step();
      expect_stat("t4_after_abort", 2'b10, 1'b0, 1'b0, 3, 2'b00);
      check_state("t4_state", S_STACK);

      // clr in the middle of a replay
      do_clr();
      op(1, 0, 2'b01);
      op(1, 0, 2'b11);
      k = cyc + 1;
      read = 1'b1;
      expect_ev(1'b0, 2'b01, k + 4);
      run_to(k + 5);
      expect_stat("t5_before_clr", 2'b11, 1'b0, 1'b0, 2, 2'b01);
      clr = 1'b1;
      read = 1'b0;
      step();
      clr = 1'b0;
      expect_stat("t5_clr_mid", 2'b00, 1'b1, 1'b0, 0, 2'b00);
      check_state("t5_state", S_STACK);
      drain("t5_mid", 10);

      // Replay of an empty stack
      k = cyc + 1;
      read = 1'b1;
      expect_ev(1'b1, 2'b00, k + 1);
      step();
      step();
      read = 1'b0;
      drain("t5_empty", 10);
      repeat (6) step();
      expect_stat("t5_empty_after", 2'b00, 1'b1, 1'b0, 0, 2'b00);

      drain("final", 5);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
